filtr_seq_ctrl: RTL and testbench

//  Sequencer for the sample-domain filter chain: input converter -> IIR filter -> output converter.

---
 rtl/filtr_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_filtr_seq_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filtr_seq_ctrl.sv
// Sequencer for the sample-domain filter chain: loads a shadow coefficient bank into
// the IIR filter, then paces converter starts once per sample period and flags overruns.
module filtr_seq_ctrl #(
  parameter int CLK_REF = 50_000_000,
  parameter int SAMPL_T = 1_000_000,
  parameter int NCOEF   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cfg_commit,
  input  logic        run_en,
  input  logic        err_clr,
  input  logic        conv_done,
  output logic        filt_enabel,
  output logic [2:0]  filt_addr,
  output logic [31:0] filt_data,
  output logic        conv_start,
  output logic        filt_start,
  output logic        busy,
  output logic        err_overrun,
  output logic [15:0] sample_cnt
);

  localparam int T  = CLK_REF / SAMPL_T;
  localparam int TW = $clog2(T);
  localparam logic [TW-1:0] T_LAST  = TW'(T - 1);
  localparam logic [2:0]    K_LAST  = 3'(NCOEF - 1);
  localparam logic [3:0]    NCOEF_W = 4'(NCOEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_CONV = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s, tick_inc_s;
  logic [2:0]    k_r, k_s;
  logic          commit_pend_r, commit_pend_s;
  logic [15:0]   cnt_r, cnt_s, cnt_nx_s;
  logic          fstart_r, fstart_s, fstart_nx_s;
  logic          err_r, err_s;
  logic          cstart_r, cstart_s;
  logic          overrun_s;
  logic          load_s;
  logic          shadow_we_s;
  logic          en_r;
  logic [2:0]    addr_r;
  logic [31:0]   data_r;
  logic          busy_r;
  logic [31:0]   shadow_r [0:7];

  // Next-state, period counter and per-sample bookkeeping.
  always_comb begin
    state_s    = state_r;
    tick_s     = tick_r;
    k_s        = k_r;
    cnt_s      = cnt_r;
    fstart_s   = fstart_r;
    cstart_s   = 1'b0;
    overrun_s  = 1'b0;
    tick_inc_s = (tick_r == T_LAST) ? {TW{1'b0}} : tick_r + TW'(1);

    case (state_r)
      S_IDLE: begin
        if (commit_pend_r) begin
          state_s = S_LOAD;
          k_s     = 3'd0;
        end else if (run_en) begin
          state_s = S_WAIT;
          tick_s  = {TW{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (k_r == K_LAST) begin
          k_s = 3'd0;
          if (run_en) begin
            state_s = S_WAIT;
            tick_s  = {TW{1'b0}};
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          k_s = k_r + 3'd1;
        end
      end
      S_WAIT: begin
        tick_s = tick_inc_s;
        if (tick_r == T_LAST) begin
          if (!run_en || commit_pend_r) begin
            state_s = S_IDLE;
          end else begin
            state_s  = S_CONV;
            cstart_s = 1'b1;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_CONV: begin
        // A result arriving on the deadline cycle still counts as on time.
        tick_s = tick_inc_s;
        if (conv_done) begin
          cnt_s    = cnt_r + 16'd1;
          fstart_s = 1'b1;
          state_s  = S_WAIT;
        end else if (tick_r == T_LAST) begin
          overrun_s = 1'b1;
          fstart_s  = 1'b0;
          state_s   = S_IDLE;
        end else begin
          state_s = S_CONV;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    load_s      = (state_s == S_LOAD);
    cnt_nx_s    = load_s ? 16'd0 : cnt_s;
    fstart_nx_s = load_s ? 1'b0 : fstart_s;

    if (overrun_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end

    if (cfg_commit) begin
      commit_pend_s = 1'b1;
    end else if ((state_r == S_LOAD) && (k_r == 3'd0)) begin
      commit_pend_s = 1'b0;
    end else begin
      commit_pend_s = commit_pend_r;
    end

    shadow_we_s = cfg_we && ({1'b0, cfg_addr} < NCOEF_W) && (state_r != S_LOAD);
  end

  // State, shadow bank and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      tick_r        <= {TW{1'b0}};
      k_r           <= 3'd0;
      commit_pend_r <= 1'b0;
      cnt_r         <= 16'd0;
      fstart_r      <= 1'b0;
      err_r         <= 1'b0;
      cstart_r      <= 1'b0;
      en_r          <= 1'b0;
      addr_r        <= 3'd0;
      data_r        <= 32'd0;
      busy_r        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_r[i] <= 32'd0;
      end
    end else begin
      state_r       <= state_s;
      tick_r        <= tick_s;
      k_r           <= k_s;
      commit_pend_r <= commit_pend_s;
      cnt_r         <= cnt_nx_s;
      fstart_r      <= fstart_nx_s;
      err_r         <= err_s;
      cstart_r      <= cstart_s;
      en_r          <= load_s;
      addr_r        <= load_s ? k_s : 3'd0;
      data_r        <= load_s ? shadow_r[k_s] : 32'd0;
      busy_r        <= (state_s != S_IDLE);
      if (shadow_we_s) begin
        shadow_r[cfg_addr] <= cfg_data;
      end
    end
  end

  assign filt_enabel = en_r;
  assign filt_addr   = addr_r;
  assign filt_data   = data_r;
  assign conv_start  = cstart_r;
  assign filt_start  = fstart_r;
  assign busy        = busy_r;
  assign err_overrun = err_r;
  assign sample_cnt  = cnt_r;

endmodule

// File: tb/tb_filtr_seq_ctrl.sv
// Directed bench for filtr_seq_ctrl: a queue/period based reference model checked
// every cycle, plus literal expectations for bursts, pacing, overruns and resets.
module tb_filtr_seq_ctrl;

  localparam int T     = 50;
  localparam int NCOEF = 5;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_commit;
  logic        run_en;
  logic        err_clr;
  logic        conv_done;
  logic        filt_enabel;
  logic [2:0]  filt_addr;
  logic [31:0] filt_data;
  logic        conv_start;
  logic        filt_start;
  logic        busy;
  logic        err_overrun;
  logic [15:0] sample_cnt;

  int total;
  int bad;

  bit resp_en;
  int resp_dly;
  bit extra_done;

  // reference model state
  bit          mv;
  int          qa[$];
  logic [31:0] qd[$];
  bit          running, awaiting, pend;
  int          pos;
  logic [31:0] sh [8];
  bit          e_cs, e_fs, e_err;
  logic [15:0] e_cnt;

  int          cyc;
  int          cs_q[$];
  int          ba[$];
  logic [31:0] bd[$];

  filtr_seq_ctrl #(.CLK_REF(50_000_000), .SAMPL_T(1_000_000), .NCOEF(NCOEF)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .run_en(run_en), .err_clr(err_clr), .conv_done(conv_done),
    .filt_enabel(filt_enabel), .filt_addr(filt_addr), .filt_data(filt_data),
    .conv_start(conv_start), .filt_start(filt_start), .busy(busy),
    .err_overrun(err_overrun), .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter stand-in: answers each start after resp_dly cycles when enabled.
  initial begin : responder
    int cd;
    cd = 0;
    conv_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      conv_done = extra_done;
      if (cd > 0) begin
        cd--;
        if (cd == 0) conv_done = 1'b1;
      end else if (conv_start && resp_en) begin
        cd = resp_dly;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Called at each falling edge: compare, record, then advance over the next rising edge.
  task automatic model_cycle();
    logic [55:0] act, want;
    bit          x_en, ld, first, ov;
    logic [2:0]  x_ad;
    logic [31:0] x_d;
    cyc++;
    if (filt_enabel) begin
      ba.push_back(int'(filt_addr));
      bd.push_back(filt_data);
    end
    if (conv_start) cs_q.push_back(cyc);
    if (mv) begin
      x_en = (qa.size() > 0);
      x_ad = x_en ? 3'(qa[0]) : 3'd0;
      x_d  = x_en ? qd[0] : 32'd0;
      want = {x_en, x_ad, x_d, e_cs, e_fs, (x_en || running), e_err, e_cnt};
      act  = {filt_enabel, filt_addr, filt_data, conv_start, filt_start, busy, err_overrun, sample_cnt};
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL model cyc=%0d got=%h want=%h", cyc, act, want);
      end
    end
    if (reset) begin
      qa.delete();
      qd.delete();
      running = 0; awaiting = 0; pend = 0; pos = 0;
      for (int i = 0; i < 8; i++) sh[i] = 32'd0;
      e_cs = 0; e_fs = 0; e_err = 0; e_cnt = 16'd0;
      mv = 1;
    end else begin
      ld    = (qa.size() > 0);
      first = ld && (qa.size() == NCOEF);
      ov    = 0;
      e_cs  = 0;
      if (ld) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        if (qa.size() == 0 && run_en) begin running = 1; pos = 0; end
      end else if (!running) begin
        if (pend) begin
          for (int k = 0; k < NCOEF; k++) begin qa.push_back(k); qd.push_back(sh[k]); end
          e_cnt = 16'd0;
          e_fs  = 0;
        end else if (run_en) begin
          running = 1; pos = 0;
        end
      end else if (awaiting) begin
        if (conv_done) begin
          e_cnt++; e_fs = 1; awaiting = 0; pos = (pos + 1) % T;
        end else if (pos == T - 1) begin
          ov = 1; e_fs = 0; running = 0; awaiting = 0;
        end else begin
          pos++;
        end
      end else begin
        if (pos == T - 1) begin
          if (run_en && !pend) begin awaiting = 1; pos = 0; e_cs = 1; end
          else running = 0;
        end else begin
          pos++;
        end
      end
      if (cfg_commit) pend = 1;
      else if (first) pend = 0;
      if (ov) e_err = 1;
      else if (err_clr) e_err = 0;
      if (cfg_we && cfg_addr < NCOEF && !ld) sh[cfg_addr] = cfg_data;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 filt_enabel, 1 conv_start, 2 err_overrun, other: sample_cnt == target
  task automatic wait_sig(input int which, input int target, input int bound, input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      step(1);
      case (which)
        0:       hit = filt_enabel;
        1:       hit = conv_start;
        2:       hit = err_overrun;
        default: hit = (int'(sample_cnt) == target);
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL timeout_%s got=no_event want=event_within_%0d_cycles", nm, bound);
    end
  endtask

  task automatic chk_burst(input string nm, input logic [31:0] base, input logic [31:0] inc);
    chk({nm, "_len"}, 64'(ba.size()), 64'(NCOEF));
    for (int i = 0; i < NCOEF && i < ba.size(); i++) begin
      chk(nm, {32'(ba[i]), bd[i]}, {32'(i), base + 32'(i) * inc});
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mv = 0;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 32'd0;
    cfg_commit = 1'b0; run_en = 1'b0; err_clr = 1'b0;
    resp_en = 0; resp_dly = 3; extra_done = 0;

    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_state", {busy, filt_enabel, conv_start, filt_start, err_overrun, sample_cnt, filt_addr},
        64'd0);
    chk("reset_data", 64'(filt_data), 64'd0);

    // shadow[0..4] = 1..5, plus an out-of-range write
    for (int i = 0; i < NCOEF; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 32'(i + 1);
      step(1);
    end
    cfg_addr = 3'd7; cfg_data = 32'hDEAD_BEEF;
    step(1);
    cfg_we = 1'b0;
    ba.delete(); bd.delete();
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    step(10);
    chk_burst("burst1", 32'd1, 32'd1);
    chk("burst1_idle", 64'(busy), 64'd0);

    // periodic sampling, answer 3 cycles after each start
    cs_q.delete();
    resp_en = 1; resp_dly = 3;
    run_en = 1'b1;
    wait_sig(3, 3, 400, "three_samples");
    chk("cnt3", 64'(sample_cnt), 64'd3);
    chk("fstart_after_done", 64'(filt_start), 64'd1);
    chk("cs_count", 64'(cs_q.size()), 64'd3);
    if (cs_q.size() >= 3) begin
      chk("period_a", 64'(cs_q[1] - cs_q[0]), 64'd50);
      chk("period_b", 64'(cs_q[2] - cs_q[1]), 64'd50);
    end

    // overrun: no answer
    resp_en = 0;
    cs_q.delete();
    wait_sig(2, 0, 200, "overrun");
    chk("ovr_err", 64'(err_overrun), 64'd1);
    chk("ovr_fstart", 64'(filt_start), 64'd0);
    chk("ovr_idle", 64'(busy), 64'd0);
    if (cs_q.size() > 0) chk("ovr_at_deadline", 64'(cyc + 1 - cs_q[cs_q.size() - 1]), 64'd50);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", 64'(err_overrun), 64'd0);

    // clear in the same cycle as a new overrun: set wins
    wait_sig(1, 0, 100, "start_for_setwins");
    step(49);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_set_wins", 64'(err_overrun), 64'd1);

    // done exactly on the deadline cycle is a success
    err_clr = 1'b1; resp_en = 1; resp_dly = 49;
    step(1);
    err_clr = 1'b0;
    chk("err_clr2", 64'(err_overrun), 64'd0);
    wait_sig(3, 4, 200, "deadline_done");
    resp_dly = 3;
    step(2);
    chk("deadline_no_err", 64'(err_overrun), 64'd0);
    chk("deadline_cnt", 64'(sample_cnt), 64'd4);

    // commit during a conversion
    wait_sig(1, 0, 200, "start_for_commit");
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    ba.delete(); bd.delete();
    wait_sig(0, 0, 100, "load_after_commit");
    chk("commit_cnt_reset", 64'(sample_cnt), 64'd0);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 32'd99;
    step(1);
    cfg_we = 1'b0;
    step(10);
    chk_burst("burst2", 32'd1, 32'd1);
    run_en = 1'b0;
    step(110);
    chk("stop_idle", 64'(busy), 64'd0);
    ba.delete(); bd.delete();
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    step(10);
    chk_burst("burst3", 32'd1, 32'd1);

    // run_en dropped mid-conversion
    run_en = 1'b1;
    wait_sig(1, 0, 100, "start_for_stop");
    run_en = 1'b0;
    step(60);
    chk("stop_cnt", 64'(sample_cnt), 64'd1);
    chk("stop_busy", 64'(busy), 64'd0);

    // conv_done while idle is ignored
    extra_done = 1;
    step(1);
    extra_done = 0;
    step(2);
    chk("stray_done_cnt", 64'(sample_cnt), 64'd1);
    chk("stray_done_err", 64'(err_overrun), 64'd0);

    // reset on the third LOAD cycle
    for (int i = 0; i < NCOEF; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 32'(i + 10);
      step(1);
    end
    cfg_we = 1'b0;
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    wait_sig(0, 0, 10, "load_for_reset");
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midload_reset", {busy, filt_enabel, conv_start, filt_start, err_overrun, sample_cnt, filt_addr},
        64'd0);
    chk("midload_reset_data", 64'(filt_data), 64'd0);
    ba.delete(); bd.delete();
    step(1);
    cfg_commit = 1'b1;
    step(1);
    cfg_commit = 1'b0;
    step(10);
    chk_burst("burst_zeroed", 32'd0, 32'd0);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
